// File: rtl/chunked_add_seq.sv
// Multi-cycle wide adder: adds chunk_width bits per clock with a registered chunk carry.
// Optional subtract support (sub port, ~b with carry-in 1) is enabled by CHUNKED_ADD_SUB_EN.
//
// state | meaning
// IDLE  | waiting for req; out/carry_out hold the last result
// RUN   | adding one chunk per edge, lowest chunk first
module chunked_add_seq #(
    parameter int width       = 32,
    parameter int chunk_width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
`ifdef CHUNKED_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             ack,
    output logic [width-1:0] out,
    output logic             carry_out
);

    localparam int num_chunks = width / chunk_width;
    localparam int cnt_w      = (num_chunks > 1) ? $clog2(num_chunks) : 1;
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(num_chunks - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [cnt_w-1:0]   cnt_q;
    logic               carry_q;
    logic [width-1:0]   a_sh, b_sh;
    logic [chunk_width:0] sum;
    logic [width-1:0]   res_next;
    logic [width-1:0]   b_in;
    logic               cin;
    logic               accept;
    logic               last;

`ifdef CHUNKED_ADD_SUB_EN
    assign cin  = sub;
    assign b_in = sub ? ~b : b;
`else
    assign cin  = 1'b0;
    assign b_in = b;
`endif

    assign busy = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == last_cnt) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sum = {1'b0, a_sh[chunk_width-1:0]} + {1'b0, b_sh[chunk_width-1:0]}
            + {{chunk_width{1'b0}}, carry_q};
    end

    // New chunk enters at the top; after num_chunks shifts chunk k sits at its final position.
    generate
        if (num_chunks == 1) begin : g_single
            assign res_next = sum[chunk_width-1:0];
        end else begin : g_multi
            logic [width-chunk_width-1:0] res_hi;
            assign res_next = {sum[chunk_width-1:0], res_hi};
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    res_hi <= '0;
                end else if (state_q == RUN) begin
                    res_hi <= res_next[width-1:chunk_width];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            ack       <= 1'b0;
            out       <= '0;
            carry_out <= 1'b0;
        end else begin
            ack <= last;
            if (accept) begin
                a_sh    <= a;
                b_sh    <= b_in;
                carry_q <= cin;
                cnt_q   <= '0;
            end else if (state_q == RUN) begin
                a_sh    <= a_sh >> chunk_width;
                b_sh    <= b_sh >> chunk_width;
                carry_q <= sum[chunk_width];
                cnt_q   <= cnt_q + cnt_w'(1);
                if (last) begin
                    out       <= res_next;
                    carry_out <= sum[chunk_width];
                end
            end
        end
    end

endmodule

// File: tb/tb_chunked_add_seq.sv
// Self-checking bench for chunked_add_seq (default 32/8 parameters).
// Subtract cases are exercised when CHUNKED_ADD_SUB_EN is defined.
module tb_chunked_add_seq;

    localparam int W = 32;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic [W-1:0] a, b;
`ifdef CHUNKED_ADD_SUB_EN
    logic         sub;
`endif
    logic         busy, ack, carry_out;
    logic [W-1:0] out;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    chunked_add_seq #(.width(W), .chunk_width(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a         (a),
        .b         (b),
`ifdef CHUNKED_ADD_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .ack       (ack),
        .out       (out),
        .carry_out (carry_out)
    );

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular arithmetic; carry = unsigned overflow (add) or no-borrow (sub)
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input bit s);
        logic [W-1:0] d;
        if (s) begin
            d = x - y;
            return {(x >= y), d};
        end
        return {1'b0, x} + {1'b0, y};
    endfunction

    task automatic start(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input bit s_v);
        @(negedge clk);
        req = 1'b1;
        a   = a_v;
        b   = b_v;
`ifdef CHUNKED_ADD_SUB_EN
        sub = s_v;
`endif
        @(posedge clk);
        #1;
        req = 1'b0;
        a   = $urandom;
        b   = $urandom;
`ifdef CHUNKED_ADD_SUB_EN
        sub = 1'($urandom_range(1, 0));
`endif
    endtask

    task automatic finish_op(input string tag, input logic [W:0] exp);
        for (int n = 1; n <= N; n++) begin
            @(negedge clk);
            chk({tag, " busy/ack run"}, {31'd0, busy, ack}, 33'b10);
        end
        @(negedge clk);
        chk({tag, " busy/ack done"}, {31'd0, busy, ack}, 33'b01);
        chk({tag, " result"}, {carry_out, out}, exp);
        @(negedge clk);
        chk({tag, " ack single"}, {32'd0, ack}, 33'd0);
    endtask

    task automatic op(input string tag, input logic [W-1:0] a_v, input logic [W-1:0] b_v, input bit s_v);
        start(a_v, b_v, s_v);
        finish_op(tag, model(a_v, b_v, s_v));
    endtask

    initial begin
        int acks, ack_n, t1, t2;
        logic [W:0] r1, r2, res;
        logic [W-1:0] ra, rb;
        bit rs;

        rst = 1'b0;
        req = 1'b0;
        a   = '0;
        b   = '0;
`ifdef CHUNKED_ADD_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset busy/ack", {31'd0, busy, ack}, 33'd0);
        chk("reset result", {carry_out, out}, 33'd0);
        rst = 1'b1;

        op("add_1_1", 32'h1, 32'h1, 1'b0);
        op("ripple_full", 32'hFFFF_FFFF, 32'h1, 1'b0);
        op("ripple_half", 32'h0000_FFFF, 32'h1, 1'b0);

        repeat (3) @(negedge clk);
        chk("hold idle", {carry_out, out}, {1'b0, 32'h0001_0000});

        // second req during RUN must be ignored
        start(32'd3, 32'd4, 1'b0);
        acks  = 0;
        ack_n = 0;
        res   = '0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (ack) begin
                acks++;
                if (acks == 1) begin
                    ack_n = n;
                    res   = {carry_out, out};
                end
            end
            if (n == 2) begin
                req = 1'b1;
                a   = 32'd7;
                b   = 32'd7;
            end else begin
                a = $urandom;
                b = $urandom;
                if (n >= 4) req = 1'b0;
            end
        end
        chk("busyprot ack count", 33'(acks), 33'd1);
        chk("busyprot ack cycle", 33'(ack_n), 33'd5);
        chk("busyprot result", res, {1'b0, 32'd7});

        // req held high: second op accepted on the edge after the ack cycle
        @(negedge clk);
        req = 1'b1;
        a   = 32'd10;
        b   = 32'd20;
        @(posedge clk);
        #1;
        a = 32'd5;
        b = 32'd6;
        acks = 0;
        t1 = 0;
        t2 = 0;
        r1 = '0;
        r2 = '0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (ack) begin
                acks++;
                if (acks == 1) begin
                    t1 = n;
                    r1 = {carry_out, out};
                end else begin
                    t2 = n;
                    r2 = {carry_out, out};
                end
            end
            if (n == 6) req = 1'b0;
        end
        chk("b2b ack count", 33'(acks), 33'd2);
        chk("b2b ack spacing", 33'(t2 - t1), 33'd5);
        chk("b2b first cycle", 33'(t1), 33'd5);
        chk("b2b first result", r1, 33'd30);
        chk("b2b second result", r2, 33'd11);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'b0;
`ifdef CHUNKED_ADD_SUB_EN
            rs = 1'($urandom_range(1, 0));
`endif
            op("random", ra, rb, rs);
        end

        // reset during RUN aborts with no ack
        start($urandom, $urandom, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrun reset busy/ack", {31'd0, busy, ack}, 33'd0);
        chk("midrun reset result", {carry_out, out}, 33'd0);
        @(negedge clk);
        rst  = 1'b1;
        acks = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("midrun no ack", 33'(acks), 33'd0);
        op("post_reset", 32'h1234_5678, 32'h0FED_CBA9, 1'b0);

`ifdef CHUNKED_ADD_SUB_EN
        op("sub_5_7", 32'd5, 32'd7, 1'b1);
        chk("sub_5_7 const", {carry_out, out}, {1'b0, 32'hFFFF_FFFE});
        op("sub_7_5", 32'd7, 32'd5, 1'b1);
        chk("sub_7_5 const", {carry_out, out}, {1'b1, 32'h0000_0002});
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
